// File: rtl/cpu_types_pkg.sv
// Shared types for the ALU board-test front-end.
//   aluop_t      - 4-bit ALU opcode as driven onto the ALU interface
//   seq_state_t  - operand sequencer FSM states (encoding shown on LEDs)
//   KEY_*        - bit positions of the pushbuttons inside KEY[3:0]
//   sign_fill    - widens the 16-bit switch word using switch 16 as fill bit
package cpu_types_pkg;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0,
    ALU_SRL  = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_SUB  = 4'h3,
    ALU_AND  = 4'h4,
    ALU_OR   = 4'h5,
    ALU_XOR  = 4'h6,
    ALU_NOR  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9
  } aluop_t;

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } seq_state_t;

  localparam int KEY_ENTER = 0;
  localparam int KEY_REOP  = 1;
  localparam int KEY_BACK  = 2;
  localparam int KEY_CLEAR = 3;

  // Switch 16 replicates into the upper half so negative operands can be
  // entered from a 16-bit switch bank.
  function automatic logic [31:0] sign_fill(input logic [16:0] sw);
    return {{16{sw[16]}}, sw[15:0]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser + debouncer for one raw active-low pushbutton.
//   clk_i    - system clock
//   rst_ni   - asynchronous active-low reset
//   key_i    - raw (asynchronous, bouncing) key level, 0 = pressed
//   press_o  - one-cycle pulse on each accepted press (debounced 1->0)
// SYNC_STAGES must be at least 2.
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic press_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   press_q, press_d;

  // Synchroniser idles at 1 so a reset never looks like a held key.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], key_i};
  end

  assign level = sync_q[SYNC_STAGES-1];

  // Counter only advances over an unbroken run of disagreeing samples;
  // the level is accepted on the run's DEBOUNCE_CYCLES-th sample.
  always_comb begin
    cnt_d   = '0;
    deb_d   = deb_q;
    press_d = 1'b0;
    if (level != deb_q) begin
      if (cnt_q == CNT_MAX) begin
        deb_d   = level;
        press_d = deb_q;  // only the 1->0 flip is a press
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      deb_q   <= 1'b1;
      press_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      press_q <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// Board front-end that walks the user through A, B, opcode, execute, show.
//   CLK, nRST          - clock, asynchronous active-low reset
//   SW[17:0]           - raw switches: [15:0] data, [16] sign fill, [17] spare
//   KEY[3:0]           - raw active-low buttons: enter, re-op, back, clear
//   alu_port_o, alu_*  - ALU result and {negative, overflow, zero} flags
//   port_a/port_b      - registered operands to the ALU
//   opcode             - registered ALU opcode
//   alu_go             - high for the single EXEC cycle
//   result_q/flags_q   - result and flags captured in EXEC, for display
//   result_valid       - high while showing the result
//   state_o            - FSM state encoding, for LEDs
module alu_operand_sequencer
  import cpu_types_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [17:0] SW,
  input  logic [3:0]  KEY,
  input  logic [31:0] alu_port_o,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  input  logic        alu_zero,
  output logic [31:0] port_a,
  output logic [31:0] port_b,
  output aluop_t      opcode,
  output logic        alu_go,
  output logic [31:0] result_q,
  output logic [2:0]  flags_q,
  output logic        result_valid,
  output logic [2:0]  state_o
);

  logic [3:0]  press;
  logic [16:0] sw_sync_q [SYNC_STAGES];
  logic [16:0] sw_sync;
  logic        unused_sw;

  seq_state_t  state_q, state_d;
  logic [31:0] port_a_d, port_b_d, result_d;
  aluop_t      opcode_d;
  logic [2:0]  flags_d;

  assign unused_sw = SW[17];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_key (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .key_i  (KEY[gi]),
        .press_o(press[gi])
      );
    end

    // Switches are levels sampled only on a press, so no debounce needed.
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sw_sync
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)        sw_sync_q[gi] <= '0;
        else if (gi == 0) sw_sync_q[gi] <= SW[16:0];
        else              sw_sync_q[gi] <= sw_sync_q[(gi == 0) ? 0 : gi-1];
      end
    end
  endgenerate

  assign sw_sync = sw_sync_q[SYNC_STAGES-1];

  // Within each state enter is tested before back/re-op, which together with
  // clear being tested first gives clear > enter > back > re-op.
  always_comb begin
    state_d  = state_q;
    port_a_d = port_a;
    port_b_d = port_b;
    opcode_d = opcode;
    result_d = result_q;
    flags_d  = flags_q;
    if (press[KEY_CLEAR]) begin
      state_d  = S_A;
      port_a_d = '0;
      port_b_d = '0;
      opcode_d = ALU_SLL;
      result_d = '0;
      flags_d  = '0;
    end else begin
      case (state_q)
        S_A: if (press[KEY_ENTER]) begin
          port_a_d = sign_fill(sw_sync);
          state_d  = S_B;
        end
        S_B: if (press[KEY_ENTER]) begin
          port_b_d = sign_fill(sw_sync);
          state_d  = S_OP;
        end else if (press[KEY_BACK]) begin
          state_d = S_A;
        end
        S_OP: if (press[KEY_ENTER]) begin
          opcode_d = aluop_t'(sw_sync[3:0]);
          state_d  = S_EXEC;
        end else if (press[KEY_BACK]) begin
          state_d = S_B;
        end
        S_EXEC: begin
          result_d = alu_port_o;
          flags_d  = {alu_negative, alu_overflow, alu_zero};
          state_d  = S_SHOW;
        end
        S_SHOW: if (press[KEY_ENTER]) begin
          state_d = S_A;
        end else if (press[KEY_REOP]) begin
          state_d = S_OP;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= S_A;
      port_a   <= '0;
      port_b   <= '0;
      opcode   <= ALU_SLL;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      port_a   <= port_a_d;
      port_b   <= port_b_d;
      opcode   <= opcode_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  // Decoded from state so a reset during EXEC drops the strobe at once.
  assign alu_go       = (state_q == S_EXEC);
  assign result_valid = (state_q == S_SHOW);
  assign state_o      = state_q;

endmodule
